// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use / RAW hazard detection, stall counter
// and EX-stage operand forwarding from the MEM and WB stages.
module id_ex_stage #(
  parameter int FWD_EN = 1
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rD1,
  input  logic [31:0] id_rD2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        id_alua_sel,
  input  logic        id_alub_sel,
  input  logic [3:0]  id_alu_op,
  input  logic        id_rf_we,
  input  logic [1:0]  id_wd_sel,
  input  logic        id_is_branch,
  input  logic        mem_rf_we,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_wd,
  input  logic        wb_rf_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_wd,
  input  logic        flush_ex,
  output logic        ex_valid,
  output logic        ex_rf_we,
  output logic        ex_is_branch,
  output logic        ex_alua_sel,
  output logic        ex_alub_sel,
  output logic [3:0]  ex_alu_op,
  output logic [1:0]  ex_wd_sel,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_rD1,
  output logic [31:0] ex_rD2,
  output logic        stall_id,
  output logic [31:0] stall_cnt
);

  logic        valid_q, valid_d;
  logic        rf_we_q, rf_we_d;
  logic        is_branch_q, is_branch_d;
  logic        alua_q, alua_d;
  logic        alub_q, alub_d;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [1:0]  wd_sel_q, wd_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] rD1_q, rD1_d;
  logic [31:0] rD2_q, rD2_d;
  logic [31:0] cnt_q, cnt_d;

  logic src1_live, src2_live;
  logic ex_hit, mem_hit, load_use, hazard, bubble;

  // A source only participates in hazard checks if it is read and is not x0.
  assign src1_live = id_rs1_used & (id_rs1 != 5'd0);
  assign src2_live = id_rs2_used & (id_rs2 != 5'd0);

  assign ex_hit  = valid_q & rf_we_q &
                   ((src1_live & (id_rs1 == rd_q)) | (src2_live & (id_rs2 == rd_q)));
  assign mem_hit = mem_rf_we &
                   ((src1_live & (id_rs1 == mem_rd)) | (src2_live & (id_rs2 == mem_rd)));
  assign load_use = ex_hit & (wd_sel_q == 2'b01);

  assign hazard   = (FWD_EN != 0) ? load_use : (ex_hit | mem_hit);
  assign stall_id = hazard & ~flush_ex & ~cpu_rst;
  assign bubble   = flush_ex | ~id_valid | stall_id;

  always_comb begin
    valid_d     = 1'b0;
    rf_we_d     = 1'b0;
    is_branch_d = 1'b0;
    alua_d      = 1'b0;
    alub_d      = 1'b0;
    alu_op_d    = 4'd0;
    wd_sel_d    = 2'd0;
    rd_d        = 5'd0;
    rs1_d       = 5'd0;
    rs2_d       = 5'd0;
    pc_d        = 32'd0;
    imm_d       = 32'd0;
    rD1_d       = 32'd0;
    rD2_d       = 32'd0;
    if (!bubble) begin
      valid_d     = 1'b1;
      rf_we_d     = id_rf_we;
      is_branch_d = id_is_branch;
      alua_d      = id_alua_sel;
      alub_d      = id_alub_sel;
      alu_op_d    = id_alu_op;
      wd_sel_d    = id_wd_sel;
      rd_d        = id_rd;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      pc_d        = id_pc;
      imm_d       = id_imm;
      // The regfile write in WB lands after the ID read, so bypass it here.
      rD1_d = (wb_rf_we && wb_rd != 5'd0 && wb_rd == id_rs1) ? wb_wd : id_rD1;
      rD2_d = (wb_rf_we && wb_rd != 5'd0 && wb_rd == id_rs2) ? wb_wd : id_rD2;
    end
  end

  assign cnt_d = (stall_id && cnt_q != 32'hFFFF_FFFF) ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      valid_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      is_branch_q <= 1'b0;
      alua_q      <= 1'b0;
      alub_q      <= 1'b0;
      alu_op_q    <= 4'd0;
      wd_sel_q    <= 2'd0;
      rd_q        <= 5'd0;
      rs1_q       <= 5'd0;
      rs2_q       <= 5'd0;
      pc_q        <= 32'd0;
      imm_q       <= 32'd0;
      rD1_q       <= 32'd0;
      rD2_q       <= 32'd0;
      cnt_q       <= 32'd0;
    end else begin
      valid_q     <= valid_d;
      rf_we_q     <= rf_we_d;
      is_branch_q <= is_branch_d;
      alua_q      <= alua_d;
      alub_q      <= alub_d;
      alu_op_q    <= alu_op_d;
      wd_sel_q    <= wd_sel_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rD1_q       <= rD1_d;
      rD2_q       <= rD2_d;
      cnt_q       <= cnt_d;
    end
  end

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    ex_rD1 = rD1_q;
    ex_rD2 = rD2_q;
    if (FWD_EN != 0) begin
      if (mem_rf_we && mem_rd != 5'd0 && mem_rd == rs1_q)
        ex_rD1 = mem_wd;
      else if (wb_rf_we && wb_rd != 5'd0 && wb_rd == rs1_q)
        ex_rD1 = wb_wd;
      if (mem_rf_we && mem_rd != 5'd0 && mem_rd == rs2_q)
        ex_rD2 = mem_wd;
      else if (wb_rf_we && wb_rd != 5'd0 && wb_rd == rs2_q)
        ex_rD2 = wb_wd;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_rf_we     = rf_we_q;
  assign ex_is_branch = is_branch_q;
  assign ex_alua_sel  = alua_q;
  assign ex_alub_sel  = alub_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_wd_sel    = wd_sel_q;
  assign ex_rd        = rd_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: runs a forwarding (FWD_EN=1) and a stall-only
// (FWD_EN=0) instance side by side on identical stimulus.
module tb_id_ex_stage;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_alua_sel, id_alub_sel;
  logic        id_rf_we, id_is_branch;
  logic [31:0] id_pc, id_rD1, id_rD2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic [1:0]  id_wd_sel;
  logic        mem_rf_we, wb_rf_we, flush_ex;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_wd, wb_wd;

  // Index 0 = FWD_EN=0 instance, index 1 = FWD_EN=1 instance.
  logic [1:0]       ex_valid, ex_rf_we, ex_is_branch, ex_alua_sel, ex_alub_sel, stall_id;
  logic [1:0][3:0]  ex_alu_op;
  logic [1:0][1:0]  ex_wd_sel;
  logic [1:0][4:0]  ex_rd;
  logic [1:0][31:0] ex_pc, ex_imm, ex_rD1, ex_rD2, stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 cpu_clk = ~cpu_clk;

  id_ex_stage #(.FWD_EN(0)) dut0 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rD1(id_rD1), .id_rD2(id_rD2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_alua_sel(id_alua_sel), .id_alub_sel(id_alub_sel), .id_alu_op(id_alu_op),
    .id_rf_we(id_rf_we), .id_wd_sel(id_wd_sel), .id_is_branch(id_is_branch),
    .mem_rf_we(mem_rf_we), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .flush_ex(flush_ex),
    .ex_valid(ex_valid[0]), .ex_rf_we(ex_rf_we[0]), .ex_is_branch(ex_is_branch[0]),
    .ex_alua_sel(ex_alua_sel[0]), .ex_alub_sel(ex_alub_sel[0]), .ex_alu_op(ex_alu_op[0]),
    .ex_wd_sel(ex_wd_sel[0]), .ex_rd(ex_rd[0]), .ex_pc(ex_pc[0]), .ex_imm(ex_imm[0]),
    .ex_rD1(ex_rD1[0]), .ex_rD2(ex_rD2[0]), .stall_id(stall_id[0]), .stall_cnt(stall_cnt[0])
  );

  id_ex_stage #(.FWD_EN(1)) dut1 (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rD1(id_rD1), .id_rD2(id_rD2), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_alua_sel(id_alua_sel), .id_alub_sel(id_alub_sel), .id_alu_op(id_alu_op),
    .id_rf_we(id_rf_we), .id_wd_sel(id_wd_sel), .id_is_branch(id_is_branch),
    .mem_rf_we(mem_rf_we), .mem_rd(mem_rd), .mem_wd(mem_wd),
    .wb_rf_we(wb_rf_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .flush_ex(flush_ex),
    .ex_valid(ex_valid[1]), .ex_rf_we(ex_rf_we[1]), .ex_is_branch(ex_is_branch[1]),
    .ex_alua_sel(ex_alua_sel[1]), .ex_alub_sel(ex_alub_sel[1]), .ex_alu_op(ex_alu_op[1]),
    .ex_wd_sel(ex_wd_sel[1]), .ex_rd(ex_rd[1]), .ex_pc(ex_pc[1]), .ex_imm(ex_imm[1]),
    .ex_rD1(ex_rD1[1]), .ex_rD2(ex_rD2[1]), .stall_id(stall_id[1]), .stall_cnt(stall_cnt[1])
  );

  // Reference model: the instruction occupying EX, as a plain record.
  typedef struct {
    bit        valid, rf_we, is_branch, alua, alub;
    bit [3:0]  op;
    bit [1:0]  wd_sel;
    bit [4:0]  rd, rs1, rs2;
    bit [31:0] pc, imm, d1, d2;
  } ex_t;

  ex_t       m [2];
  bit [31:0] mcnt [2];

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic quiet_side();
    mem_rf_we = 0; mem_rd = 0; mem_wd = 0;
    wb_rf_we = 0;  wb_rd = 0;  wb_wd = 0;
    flush_ex = 0;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic u1,
                          input logic u2, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic we, input logic [1:0] wsel);
    id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_used = u1; id_rs2_used = u2; id_rD1 = d1; id_rD2 = d2; id_imm = imm;
    id_rf_we = we; id_wd_sel = wsel; id_alu_op = 4'h3; id_alua_sel = 0;
    id_alub_sel = 1; id_is_branch = 0;
  endtask

  task automatic do_reset();
    cpu_rst = 1;
    quiet_side();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    cpu_rst = 0;
  endtask

  task automatic test_reset();
    cpu_rst = 1;
    quiet_side();
    flush_ex = 1;
    drive_id(1, 32'h40, 5'd2, 5'd3, 5'd4, 1, 1, 32'h1, 32'h2, 32'h3, 1, 2'b01);
    #2;
    for (int f = 0; f < 2; f++) begin
      total++;
      if (stall_id[f] !== 1'b0) begin
        bad++; $display("FAIL reset_stall f=%0d got=%b want=0", f, stall_id[f]);
      end
    end
    tick();
    for (int f = 0; f < 2; f++) begin
      total += 4;
      if (ex_valid[f] !== 1'b0) begin
        bad++; $display("FAIL reset_valid f=%0d got=%b want=0", f, ex_valid[f]);
      end
      if (stall_cnt[f] !== 32'd0) begin
        bad++; $display("FAIL reset_cnt f=%0d got=%0d want=0", f, stall_cnt[f]);
      end
      if (ex_rd[f] !== 5'd0) begin
        bad++; $display("FAIL reset_rd f=%0d got=%0d want=0", f, ex_rd[f]);
      end
      if (ex_pc[f] !== 32'd0) begin
        bad++; $display("FAIL reset_pc f=%0d got=%h want=0", f, ex_pc[f]);
      end
    end
    cpu_rst = 0;
    quiet_side();
  endtask

  task automatic test_basic();
    do_reset();
    drive_id(1, 32'h100, 5'd0, 5'd0, 5'd5, 1, 0, 32'd0, 32'd0, 32'd7, 1, 2'b00);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int f = 0; f < 2; f++) begin
      total += 4;
      if (ex_valid[f] !== 1'b1) begin
        bad++; $display("FAIL basic_valid f=%0d got=%b want=1", f, ex_valid[f]);
      end
      if (ex_rd[f] !== 5'd5) begin
        bad++; $display("FAIL basic_rd f=%0d got=%0d want=5", f, ex_rd[f]);
      end
      if (ex_imm[f] !== 32'd7) begin
        bad++; $display("FAIL basic_imm f=%0d got=%0d want=7", f, ex_imm[f]);
      end
      if (ex_pc[f] !== 32'h100) begin
        bad++; $display("FAIL basic_pc f=%0d got=%h want=100", f, ex_pc[f]);
      end
    end
  endtask

  task automatic test_load_use();
    do_reset();
    drive_id(1, 32'h200, 5'd1, 5'd0, 5'd6, 1, 0, 32'd0, 32'd0, 32'd4, 1, 2'b01);
    tick();
    drive_id(1, 32'h204, 5'd6, 5'd0, 5'd7, 1, 0, 32'd0, 32'd0, 32'd0, 1, 2'b00);
    #1;
    for (int f = 0; f < 2; f++) begin
      total++;
      if (stall_id[f] !== 1'b1) begin
        bad++; $display("FAIL lu_stall f=%0d got=%b want=1", f, stall_id[f]);
      end
    end
    tick();
    for (int f = 0; f < 2; f++) begin
      total += 3;
      if (ex_valid[f] !== 1'b0) begin
        bad++; $display("FAIL lu_bubble f=%0d got=%b want=0", f, ex_valid[f]);
      end
      if (stall_cnt[f] !== 32'd1) begin
        bad++; $display("FAIL lu_cnt f=%0d got=%0d want=1", f, stall_cnt[f]);
      end
      if (stall_id[f] !== 1'b0) begin
        bad++; $display("FAIL lu_release f=%0d got=%b want=0", f, stall_id[f]);
      end
    end
    tick();
    for (int f = 0; f < 2; f++) begin
      total += 2;
      if (ex_valid[f] !== 1'b1 || ex_rd[f] !== 5'd7) begin
        bad++; $display("FAIL lu_enter f=%0d got=%b/%0d want=1/7", f, ex_valid[f], ex_rd[f]);
      end
      if (ex_pc[f] !== 32'h204) begin
        bad++; $display("FAIL lu_pc f=%0d got=%h want=204", f, ex_pc[f]);
      end
    end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    drive_id(1, 32'h300, 5'd3, 5'd3, 5'd9, 1, 1, 32'h11, 32'h22, 32'd0, 1, 2'b00);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_rf_we = 1; mem_rd = 3; mem_wd = 32'hAA;
    wb_rf_we = 1;  wb_rd = 3;  wb_wd = 32'hBB;
    #1;
    total += 4;
    if (ex_rD1[1] !== 32'hAA) begin
      bad++; $display("FAIL fwd_mem_rs1 got=%h want=aa", ex_rD1[1]);
    end
    if (ex_rD2[1] !== 32'hAA) begin
      bad++; $display("FAIL fwd_mem_rs2 got=%h want=aa", ex_rD2[1]);
    end
    if (ex_rD1[0] !== 32'h11) begin
      bad++; $display("FAIL nofwd_rs1 got=%h want=11", ex_rD1[0]);
    end
    if (ex_rD2[0] !== 32'h22) begin
      bad++; $display("FAIL nofwd_rs2 got=%h want=22", ex_rD2[0]);
    end
    mem_rf_we = 0;
    #1;
    total++;
    if (ex_rD1[1] !== 32'hBB) begin
      bad++; $display("FAIL fwd_wb_rs1 got=%h want=bb", ex_rD1[1]);
    end
    wb_rd = 0; mem_rf_we = 1; mem_rd = 0;
    #1;
    total++;
    if (ex_rD1[1] !== 32'h11) begin
      bad++; $display("FAIL fwd_x0 got=%h want=11", ex_rD1[1]);
    end
    quiet_side();
  endtask

  task automatic test_wb_bypass();
    do_reset();
    wb_rf_we = 1; wb_rd = 8; wb_wd = 32'h1234;
    drive_id(1, 32'h400, 5'd0, 5'd8, 5'd1, 1, 1, 32'h55, 32'd0, 32'd0, 1, 2'b00);
    tick();
    quiet_side();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    for (int f = 0; f < 2; f++) begin
      total += 2;
      if (ex_rD2[f] !== 32'h1234) begin
        bad++; $display("FAIL wbbyp_rs2 f=%0d got=%h want=1234", f, ex_rD2[f]);
      end
      if (ex_rD1[f] !== 32'h55) begin
        bad++; $display("FAIL wbbyp_rs1 f=%0d got=%h want=55", f, ex_rD1[f]);
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive_id(1, 32'h500, 5'd1, 5'd0, 5'd6, 1, 0, 32'd0, 32'd0, 32'd0, 1, 2'b01);
    tick();
    drive_id(1, 32'h504, 5'd6, 5'd6, 5'd7, 1, 1, 32'd0, 32'd0, 32'd0, 1, 2'b00);
    flush_ex = 1;
    #1;
    for (int f = 0; f < 2; f++) begin
      total++;
      if (stall_id[f] !== 1'b0) begin
        bad++; $display("FAIL flush_stall f=%0d got=%b want=0", f, stall_id[f]);
      end
    end
    tick();
    flush_ex = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int f = 0; f < 2; f++) begin
      total += 2;
      if (ex_valid[f] !== 1'b0) begin
        bad++; $display("FAIL flush_bubble f=%0d got=%b want=0", f, ex_valid[f]);
      end
      if (stall_cnt[f] !== 32'd0) begin
        bad++; $display("FAIL flush_cnt f=%0d got=%0d want=0", f, stall_cnt[f]);
      end
    end
  endtask

  task automatic test_no_fwd_stall();
    do_reset();
    drive_id(1, 32'h600, 5'd1, 5'd2, 5'd4, 1, 1, 32'd0, 32'd0, 32'd0, 1, 2'b00);
    tick();
    drive_id(1, 32'h604, 5'd4, 5'd0, 5'd10, 1, 0, 32'd0, 32'd0, 32'd0, 1, 2'b00);
    #1;
    total += 2;
    if (stall_id[0] !== 1'b1) begin
      bad++; $display("FAIL nofwd_stall1 got=%b want=1", stall_id[0]);
    end
    if (stall_id[1] !== 1'b0) begin
      bad++; $display("FAIL fwd_nostall got=%b want=0", stall_id[1]);
    end
    tick();
    mem_rf_we = 1; mem_rd = 4; mem_wd = 32'h44;
    #1;
    total++;
    if (stall_id[0] !== 1'b1) begin
      bad++; $display("FAIL nofwd_stall2 got=%b want=1", stall_id[0]);
    end
    tick();
    quiet_side();
    wb_rf_we = 1; wb_rd = 4; wb_wd = 32'h44;
    #1;
    total++;
    if (stall_id[0] !== 1'b0) begin
      bad++; $display("FAIL nofwd_stall3 got=%b want=0", stall_id[0]);
    end
    tick();
    quiet_side();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total += 3;
    if (ex_valid[0] !== 1'b1 || ex_rd[0] !== 5'd10) begin
      bad++; $display("FAIL nofwd_enter got=%b/%0d want=1/10", ex_valid[0], ex_rd[0]);
    end
    if (ex_rD1[0] !== 32'h44) begin
      bad++; $display("FAIL nofwd_value got=%h want=44", ex_rD1[0]);
    end
    if (stall_cnt[0] !== 32'd2) begin
      bad++; $display("FAIL nofwd_cnt got=%0d want=2", stall_cnt[0]);
    end
  endtask

  task automatic test_unused_x0();
    do_reset();
    drive_id(1, 32'h700, 5'd1, 5'd0, 5'd6, 1, 0, 32'd0, 32'd0, 32'd0, 1, 2'b01);
    tick();
    drive_id(1, 32'h704, 5'd6, 5'd6, 5'd7, 0, 0, 32'd0, 32'd0, 32'd0, 1, 2'b00);
    #1;
    for (int f = 0; f < 2; f++) begin
      total++;
      if (stall_id[f] !== 1'b0) begin
        bad++; $display("FAIL unused_stall f=%0d got=%b want=0", f, stall_id[f]);
      end
    end
    do_reset();
    drive_id(1, 32'h710, 5'd1, 5'd0, 5'd0, 1, 0, 32'd0, 32'd0, 32'd0, 1, 2'b01);
    tick();
    drive_id(1, 32'h714, 5'd0, 5'd0, 5'd7, 1, 1, 32'd0, 32'd0, 32'd0, 1, 2'b00);
    mem_rf_we = 1; mem_rd = 0;
    #1;
    for (int f = 0; f < 2; f++) begin
      total++;
      if (stall_id[f] !== 1'b0) begin
        bad++; $display("FAIL x0_stall f=%0d got=%b want=0", f, stall_id[f]);
      end
    end
    quiet_side();
  endtask

  // Hazard rules: load-use always stalls; without forwarding any pending write
  // in EX or MEM to a live source stalls too. Flush and reset suppress it.
  function automatic bit m_stall(int f);
    bit s1, s2, in_ex, in_mem;
    s1 = id_rs1_used && id_rs1 != 0;
    s2 = id_rs2_used && id_rs2 != 0;
    in_ex  = m[f].valid && m[f].rf_we && ((s1 && id_rs1 == m[f].rd) || (s2 && id_rs2 == m[f].rd));
    in_mem = mem_rf_we && ((s1 && id_rs1 == mem_rd) || (s2 && id_rs2 == mem_rd));
    if (cpu_rst || flush_ex) return 0;
    if (f == 1) return in_ex && m[f].wd_sel == 2'b01;
    return in_ex || in_mem;
  endfunction

  function automatic bit [31:0] m_operand(int f, bit [4:0] rs, bit [31:0] latched);
    if (f == 1 && mem_rf_we && mem_rd != 0 && mem_rd == rs) return mem_wd;
    if (f == 1 && wb_rf_we && wb_rd != 0 && wb_rd == rs) return wb_wd;
    return latched;
  endfunction

  function automatic bit [31:0] wb_read(bit [4:0] rs, bit [31:0] rf);
    if (wb_rf_we && wb_rd != 0 && wb_rd == rs) return wb_wd;
    return rf;
  endfunction

  task automatic test_random();
    bit st [2];
    do_reset();
    for (int f = 0; f < 2; f++) begin
      m[f] = '{default: 0};
      mcnt[f] = 0;
    end
    for (int i = 0; i < 400; i++) begin
      cpu_rst = ($urandom_range(0, 39) == 0);
      flush_ex = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_imm = $urandom; id_rD1 = $urandom; id_rD2 = $urandom;
      id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
      id_rd = 5'($urandom_range(0, 7));
      id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_alua_sel = 1'($urandom); id_alub_sel = 1'($urandom);
      id_alu_op = 4'($urandom); id_rf_we = 1'($urandom);
      id_wd_sel = 2'($urandom_range(0, 2)); id_is_branch = 1'($urandom);
      mem_rf_we = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_wd = $urandom;
      wb_rf_we = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_wd = $urandom;
      #2;
      for (int f = 0; f < 2; f++) begin
        st[f] = m_stall(f);
        total += 14;
        if (stall_id[f] !== st[f]) begin
          bad++; $display("FAIL rnd_stall f=%0d i=%0d got=%b want=%b", f, i, stall_id[f], st[f]);
        end
        if (ex_valid[f] !== m[f].valid) begin
          bad++; $display("FAIL rnd_valid f=%0d i=%0d got=%b want=%b", f, i, ex_valid[f], m[f].valid);
        end
        if (ex_rf_we[f] !== m[f].rf_we) begin
          bad++; $display("FAIL rnd_rfwe f=%0d i=%0d got=%b want=%b", f, i, ex_rf_we[f], m[f].rf_we);
        end
        if (ex_is_branch[f] !== m[f].is_branch) begin
          bad++; $display("FAIL rnd_br f=%0d i=%0d got=%b want=%b", f, i, ex_is_branch[f], m[f].is_branch);
        end
        if (ex_alua_sel[f] !== m[f].alua) begin
          bad++; $display("FAIL rnd_alua f=%0d i=%0d got=%b want=%b", f, i, ex_alua_sel[f], m[f].alua);
        end
        if (ex_alub_sel[f] !== m[f].alub) begin
          bad++; $display("FAIL rnd_alub f=%0d i=%0d got=%b want=%b", f, i, ex_alub_sel[f], m[f].alub);
        end
        if (ex_alu_op[f] !== m[f].op) begin
          bad++; $display("FAIL rnd_op f=%0d i=%0d got=%h want=%h", f, i, ex_alu_op[f], m[f].op);
        end
        if (ex_wd_sel[f] !== m[f].wd_sel) begin
          bad++; $display("FAIL rnd_wdsel f=%0d i=%0d got=%0d want=%0d", f, i, ex_wd_sel[f], m[f].wd_sel);
        end
        if (ex_rd[f] !== m[f].rd) begin
          bad++; $display("FAIL rnd_rd f=%0d i=%0d got=%0d want=%0d", f, i, ex_rd[f], m[f].rd);
        end
        if (ex_pc[f] !== m[f].pc) begin
          bad++; $display("FAIL rnd_pc f=%0d i=%0d got=%h want=%h", f, i, ex_pc[f], m[f].pc);
        end
        if (ex_imm[f] !== m[f].imm) begin
          bad++; $display("FAIL rnd_imm f=%0d i=%0d got=%h want=%h", f, i, ex_imm[f], m[f].imm);
        end
        if (ex_rD1[f] !== m_operand(f, m[f].rs1, m[f].d1)) begin
          bad++; $display("FAIL rnd_rd1 f=%0d i=%0d got=%h want=%h", f, i, ex_rD1[f], m_operand(f, m[f].rs1, m[f].d1));
        end
        if (ex_rD2[f] !== m_operand(f, m[f].rs2, m[f].d2)) begin
          bad++; $display("FAIL rnd_rd2 f=%0d i=%0d got=%h want=%h", f, i, ex_rD2[f], m_operand(f, m[f].rs2, m[f].d2));
        end
        if (stall_cnt[f] !== mcnt[f]) begin
          bad++; $display("FAIL rnd_cnt f=%0d i=%0d got=%0d want=%0d", f, i, stall_cnt[f], mcnt[f]);
        end
      end
      for (int f = 0; f < 2; f++) begin
        if (cpu_rst) begin
          m[f] = '{default: 0};
          mcnt[f] = 0;
        end else begin
          if (st[f] && mcnt[f] != 32'hFFFF_FFFF) mcnt[f] = mcnt[f] + 1;
          if (flush_ex || !id_valid || st[f]) begin
            m[f] = '{default: 0};
          end else begin
            m[f].valid = 1; m[f].rf_we = id_rf_we; m[f].is_branch = id_is_branch;
            m[f].alua = id_alua_sel; m[f].alub = id_alub_sel; m[f].op = id_alu_op;
            m[f].wd_sel = id_wd_sel; m[f].rd = id_rd; m[f].rs1 = id_rs1; m[f].rs2 = id_rs2;
            m[f].pc = id_pc; m[f].imm = id_imm;
            m[f].d1 = wb_read(id_rs1, id_rD1);
            m[f].d2 = wb_read(id_rs2, id_rD2);
          end
        end
      end
      tick();
    end
    cpu_rst = 0;
    quiet_side();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_use();
    test_fwd_priority();
    test_wb_bypass();
    test_flush();
    test_no_fwd_stall();
    test_unused_x0();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter FWD_EN, default 1, 1 = EX-stage operand forwarding from MEM/WB enabled; 0 = every EX/MEM RAW hazard resolved by stalling.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 cpu_clk  in  1  sole clock, all state updates on rising edge.
REQ-004 cpu_rst  in  1  synchronous active-high reset.
REQ-005 id_valid  in  1  decode stage holds a real instruction.
REQ-006 id_pc, id_rD1, id_rD2, id_imm  in  32 each  decode PC, regfile reads, immediate.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  source/destination register indices.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  instruction actually reads rs1/rs2.
REQ-009 id_alua_sel, id_alub_sel  in  1 each; id_alu_op  in  4; id_rf_we  in  1; id_wd_sel  in  2 (00 ALU, 01 load, 10 PC+4); id_is_branch  in  1.
REQ-010 mem_rf_we  in  1; mem_rd  in  5; mem_wd  in  32  MEM-stage writeback candidate.
REQ-011 wb_rf_we  in  1; wb_rd  in  5; wb_wd  in  32  WB-stage regfile write port.
REQ-012 flush_ex  in  1  taken branch/jump resolved in EX this cycle.
REQ-013 ex_valid, ex_rf_we, ex_is_branch, ex_alua_sel, ex_alub_sel  out  1 each; ex_alu_op  out  4; ex_wd_sel  out  2; ex_rd  out  5.
REQ-014 ex_pc, ex_imm, ex_rD1, ex_rD2  out  32 each  ALU-facing operands (ex_rD1/ex_rD2 post-forwarding).
REQ-015 stall_id  out  1  hold PC and IF/ID this cycle.
REQ-016 stall_cnt  out  32  count of cycles with stall_id=1.

Function
REQ-017 Register captures ID fields each edge unless a bubble is inserted; latency ID->EX exactly 1 cycle.
REQ-018 Bubble = ex_valid, ex_rf_we, ex_is_branch, ex_alu_op, ex_wd_sel, ex_rd all 0; data fields SHALL be 0.
REQ-019 Bubble inserted when flush_ex=1, id_valid=0, or stall_id=1.
REQ-020 Capture bypass: if wb_rf_we & wb_rd!=0 & wb_rd==id_rs1 (rs2), captured rD1 (rD2) SHALL be wb_wd, not id_rD1 (id_rD2); applies for both FWD_EN values.
REQ-021 Load-use: stall_id=1 when ex_valid & ex_rf_we & ex_wd_sel==01 & ex_rd!=0 & ex_rd matches a used id source; lasts exactly 1 cycle.
REQ-022 FWD_EN=1: ex_rD1 = mem_wd if mem_rf_we & mem_rd!=0 & mem_rd==latched rs1; else wb_wd if wb_rf_we & wb_rd!=0 & wb_rd==rs1; else latched value; same for ex_rD2; MEM beats WB.
REQ-023 FWD_EN=0: stall_id=1 also when a used id source !=0 matches ex_rd (ex_valid & ex_rf_we) or mem_rd (mem_rf_we); ex_rD1/ex_rD2 = latched values; stall up to 2 cycles.
REQ-024 Register x0 never matches any hazard or forward comparison.
REQ-025 Unused sources (rsN_used=0) never cause stall.
REQ-026 flush_ex=1 forces stall_id=0 and a bubble, overriding any hazard in the same cycle.
REQ-027 Forwarding muxes purely combinational; stall_id combinational from current EX contents and ID inputs.
REQ-028 stall_cnt increments by 1 each cycle stall_id=1; saturates at 0xFFFFFFFF.

Reset
REQ-029 cpu_rst=1 at an edge: all EX register fields and stall_cnt become 0; ex_valid=0.
REQ-030 During reset cycle stall_id SHALL be 0 (EX is bubble); reset overrides flush_ex and capture.

Verification
REQ-031 ID addi x5 (rd=5, imm=7, pc=0x100), no hazard -> next cycle ex_valid=1, ex_rd=5, ex_imm=7, ex_pc=0x100.
REQ-032 EX holds lw x6; ID add uses rs1=6 -> stall_id=1 one cycle, ex_valid=0 next, stall_cnt=1; add then enters EX.
REQ-033 FWD_EN=1, mem_rf_we=1, mem_rd=3, mem_wd=0xAA, wb_rd=3, wb_wd=0xBB, EX rs1=3 -> ex_rD1=0xAA.
REQ-034 wb_rf_we=1, wb_rd=8, wb_wd=0x1234, ID rs2=8, id_rD2=0 -> next cycle ex_rD2=0x1234.
REQ-035 Load-use hazard and flush_ex=1 same cycle -> stall_id=0, next cycle ex_valid=0, stall_cnt unchanged.
REQ-036 FWD_EN=0, EX add x4, ID uses rs1=4 -> stall_id=1 for 2 cycles, then ID captured with wb-bypassed value.
